// File: rtl/cpu_debug_controller_pkg.sv
// Shared definitions for the rv32i run-control block: host opcodes, FSM state
// encoding and the layout of the STATUS response word.
package cpu_debug_controller_pkg;

  localparam logic [2:0] DBG_OP_STATUS     = 3'd0;
  localparam logic [2:0] DBG_OP_HALT       = 3'd1;
  localparam logic [2:0] DBG_OP_RESUME     = 3'd2;
  localparam logic [2:0] DBG_OP_STEP       = 3'd3;
  localparam logic [2:0] DBG_OP_REG_RD     = 3'd4;
  localparam logic [2:0] DBG_OP_REG_WR     = 3'd5;
  localparam logic [2:0] DBG_OP_RD_RETIRED = 3'd6;
  localparam logic [2:0] DBG_OP_RD_CYCLES  = 3'd7;

  localparam int STAT_STALL_BIT     = 0;
  localparam int STAT_HALTED_BIT    = 1;
  localparam int STAT_STEP_BUSY_BIT = 2;

  typedef enum logic [2:0] {
    ST_RUNNING   = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_HALTED    = 3'd2,
    ST_STEP_GO   = 3'd3,
    ST_STEP_WAIT = 3'd4,
    ST_REG_RD    = 3'd5,
    ST_RESP      = 3'd6
  } dbg_state_t;

  function automatic logic [31:0] status_word(input logic step_busy,
                                              input logic halted,
                                              input logic stall);
    logic [31:0] w;
    w = '0;
    w[STAT_STEP_BUSY_BIT] = step_busy;
    w[STAT_HALTED_BIT]    = halted;
    w[STAT_STALL_BIT]     = stall;
    return w;
  endfunction

endpackage

// File: rtl/cpu_debug_controller_counters.sv
// Free-running retired-instruction and unstalled-cycle counters; both wrap
// naturally at 32 bits.
module cpu_debug_controller_counters
  import cpu_debug_controller_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_retire,
  input  logic        pc_stall,
  output logic [31:0] retired,
  output logic [31:0] cycles
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      retired <= '0;
      cycles  <= '0;
    end else begin
      if (cpu_retire) retired <= retired + 32'd1;
      if (!pc_stall)  cycles  <= cycles + 32'd1;
    end
  end

endmodule

// File: rtl/cpu_debug_controller.sv
// Host run-control for the rv32i core: halt/resume/step, register-file access
// through the cm_regfile_* port, and counter readout, one response per command.
module cpu_debug_controller
  import cpu_debug_controller_pkg::*;
#(
  parameter int START_HALTED = 1,
  parameter int HALT_TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        cpu_idle,
  input  logic        cpu_retire,
  output logic        pc_stall,
  output logic [4:0]  cm_regfile_addr,
  output logic        cm_regfile_we,
  output logic [31:0] cm_regfile_write_data,
  input  logic [31:0] cm_regfile_read_data
);

  localparam int               TMO_W       = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(HALT_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
  localparam dbg_state_t       RESET_STATE = dbg_state_t'((START_HALTED != 0) ? ST_HALTED : ST_RUNNING);
  localparam logic             RESET_STALL = (START_HALTED != 0);

  dbg_state_t       state, state_d;
  logic             pc_stall_d;
  logic [31:0]      rsp_data_d;
  logic             rsp_err_d;
  logic [4:0]       rf_addr_d;
  logic             rf_we_d;
  logic [31:0]      rf_wdata_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic             step_arm, step_arm_d;
  logic             is_halted;
  logic             accept;
  logic             tmo_expired;
  logic [31:0]      retired;
  logic [31:0]      cycles;

  cpu_debug_controller_counters u_counters (
    .CLK        (CLK),
    .RST        (RST),
    .cpu_retire (cpu_retire),
    .pc_stall   (pc_stall),
    .retired    (retired),
    .cycles     (cycles)
  );

  assign is_halted   = (state == ST_HALTED);
  assign cmd_ready   = (state == ST_RUNNING) || (state == ST_HALTED);
  assign rsp_valid   = (state == ST_RESP);
  assign accept      = cmd_valid && cmd_ready;
  assign tmo_expired = (tmo == TMO_LAST);

  always_comb begin
    state_d    = state;
    pc_stall_d = pc_stall;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    rf_addr_d  = '0;
    rf_we_d    = 1'b0;
    rf_wdata_d = '0;
    tmo_d      = tmo;
    step_arm_d = step_arm;

    case (state)
      ST_RUNNING, ST_HALTED: begin
        if (accept) begin
          state_d    = ST_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          tmo_d      = '0;
          step_arm_d = 1'b0;
          case (cmd_op)
            DBG_OP_STATUS: rsp_data_d = status_word(1'b0, is_halted, pc_stall);
            DBG_OP_HALT: begin
              if (!is_halted) begin
                pc_stall_d = 1'b1;
                state_d    = ST_HALT_WAIT;
              end
            end
            DBG_OP_RESUME: pc_stall_d = 1'b0;
            DBG_OP_STEP: begin
              if (is_halted) begin
                pc_stall_d = 1'b0;
                state_d    = ST_STEP_GO;
              end else begin
                rsp_err_d  = 1'b1;
              end
            end
            DBG_OP_REG_RD: begin
              if (is_halted) begin
                rf_addr_d = cmd_addr;
                state_d   = ST_REG_RD;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            DBG_OP_REG_WR: begin
              // x0 writes go out unchanged; the core's regfile drops them.
              if (is_halted) begin
                rf_we_d    = 1'b1;
                rf_addr_d  = cmd_addr;
                rf_wdata_d = cmd_data;
              end else begin
                rsp_err_d  = 1'b1;
              end
            end
            DBG_OP_RD_RETIRED: rsp_data_d = retired;
            DBG_OP_RD_CYCLES:  rsp_data_d = cycles;
            default: ;
          endcase
        end
      end

      ST_HALT_WAIT: begin
        tmo_d = tmo + TMO_ONE;
        if (cpu_idle) begin
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          state_d   = ST_RESP;
          rsp_err_d = 1'b1;
        end
      end

      // One unstalled cycle lets exactly one fetch through.
      ST_STEP_GO: begin
        pc_stall_d = 1'b1;
        state_d    = ST_STEP_WAIT;
        step_arm_d = step_arm || !cpu_idle || cpu_retire;
      end

      // Done once the core has left idle (or retired) and parked again.
      ST_STEP_WAIT: begin
        tmo_d      = tmo + TMO_ONE;
        step_arm_d = step_arm || !cpu_idle || cpu_retire;
        if (step_arm && cpu_idle) begin
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          state_d   = ST_RESP;
          rsp_err_d = 1'b1;
        end
      end

      ST_REG_RD: begin
        rsp_data_d = cm_regfile_read_data;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = pc_stall ? ST_HALTED : ST_RUNNING;
      end

      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                 <= RESET_STATE;
      pc_stall              <= RESET_STALL;
      rsp_data              <= '0;
      rsp_err               <= 1'b0;
      cm_regfile_addr       <= '0;
      cm_regfile_we         <= 1'b0;
      cm_regfile_write_data <= '0;
      tmo                   <= '0;
      step_arm              <= 1'b0;
    end else begin
      state                 <= state_d;
      pc_stall              <= pc_stall_d;
      rsp_data              <= rsp_data_d;
      rsp_err               <= rsp_err_d;
      cm_regfile_addr       <= rf_addr_d;
      cm_regfile_we         <= rf_we_d;
      cm_regfile_write_data <= rf_wdata_d;
      tmo                   <= tmo_d;
      step_arm              <= step_arm_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_controller.sv
// Bench for cpu_debug_controller: directed run-control scenarios, then random
// commands compared against a command-level model of the controller.
module tb_cpu_debug_controller;
  import cpu_debug_controller_pkg::*;

  localparam int TMO    = 256;
  localparam int BUDGET = TMO + 20;

  logic        CLK;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cpu_idle;
  logic        cpu_retire;
  logic        pc_stall;
  logic [4:0]  cm_regfile_addr;
  logic        cm_regfile_we;
  logic [31:0] cm_regfile_write_data;
  logic [31:0] cm_regfile_read_data;

  cpu_debug_controller #(.START_HALTED(1), .HALT_TIMEOUT(TMO)) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_addr              (cmd_addr),
    .cmd_data              (cmd_data),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_data              (rsp_data),
    .rsp_err               (rsp_err),
    .cpu_idle              (cpu_idle),
    .cpu_retire            (cpu_retire),
    .pc_stall              (pc_stall),
    .cm_regfile_addr       (cm_regfile_addr),
    .cm_regfile_we         (cm_regfile_we),
    .cm_regfile_write_data (cm_regfile_write_data),
    .cm_regfile_read_data  (cm_regfile_read_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stand-in for the core's register file.
  logic [31:0] core_rf [32];
  assign cm_regfile_read_data = core_rf[cm_regfile_addr];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) core_rf[i] <= '0;
    end else if (cm_regfile_we && cm_regfile_addr != 5'd0) begin
      core_rf[cm_regfile_addr] <= cm_regfile_write_data;
    end
  end

  // Reference model state.
  logic [31:0] m_rf [32];
  logic [31:0] m_retired;
  logic [31:0] m_cycles;
  bit          m_stall;
  bit          m_halted;
  bit          rand_retire;

  always @(posedge CLK) begin
    if (RST) begin
      m_retired <= '0;
      m_cycles  <= '0;
    end else begin
      if (cpu_retire) m_retired <= m_retired + 32'd1;
      if (!m_stall)   m_cycles  <= m_cycles + 32'd1;
    end
  end

  int          we_pulses;
  int          inv_viol;
  logic [4:0]  we_addr;
  logic [31:0] we_data;
  always @(negedge CLK) begin
    if (cm_regfile_we) begin
      we_pulses <= we_pulses + 1;
      we_addr   <= cm_regfile_addr;
      we_data   <= cm_regfile_write_data;
      if (!pc_stall) inv_viol <= inv_viol + 1;
    end
  end

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cpu_retire = rand_retire ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic clear_model_rf();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  // Issue one command, wait for its response, hold it for 'hold' cycles,
  // then complete the handshake and compare everything against the model.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                        input int hold, input int idle_rise, input bit tmo_exp,
                        output int lat, output logic [31:0] rdata);
    logic [31:0] e_data;
    logic        e_err;
    logic        r_err;
    bit          exp_we;
    bit          do_step;
    bit          unstable;
    int          we0;
    string       t;
    t       = $sformatf("op%0d", op);
    e_data  = '0;
    e_err   = 1'b0;
    exp_we  = (op == DBG_OP_REG_WR) && m_halted;
    do_step = (op == DBG_OP_STEP) && m_halted;
    case (op)
      DBG_OP_STATUS:     e_data = m_halted ? 32'h3 : 32'h0;
      DBG_OP_HALT:       e_err  = !m_halted && tmo_exp;
      DBG_OP_STEP, DBG_OP_REG_RD, DBG_OP_REG_WR: begin
        e_err = !m_halted;
        if (m_halted && op == DBG_OP_REG_RD) e_data = m_rf[addr];
      end
      DBG_OP_RD_RETIRED: e_data = m_retired;
      DBG_OP_RD_CYCLES:  e_data = m_cycles;
      default: ;
    endcase
    if (exp_we && addr != 5'd0) m_rf[addr] = data;

    we0 = we_pulses;
    check({t, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    lat       = 1;
    if (op == DBG_OP_HALT && !m_halted) m_stall = 1'b1;
    if (op == DBG_OP_RESUME) m_stall = 1'b0;
    if (do_step) begin
      m_stall    = 1'b0;
      cpu_idle   = 1'b0;
      cpu_retire = 1'b1;
    end
    check({t, "_stall_after_accept"}, pc_stall, m_stall);
    if (do_step) begin
      tick();
      lat        = 2;
      m_stall    = 1'b1;
      cpu_idle   = 1'b1;
      cpu_retire = 1'b0;
      check({t, "_step_restall"}, pc_stall, 1);
    end
    while (rsp_valid !== 1'b1 && lat < BUDGET) begin
      if (idle_rise > 0 && lat == idle_rise) cpu_idle = 1'b1;
      tick();
      lat++;
    end
    check({t, "_rsp_valid"}, rsp_valid, 1);
    rdata = rsp_data;
    r_err = rsp_err;
    check({t, "_rsp_data"}, rdata, e_data);
    check({t, "_rsp_err"}, r_err, e_err);

    unstable = 1'b0;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_op    = DBG_OP_RESUME;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== rdata || rsp_err !== r_err || cmd_ready !== 1'b0)
        unstable = 1'b1;
    end
    cmd_valid = 1'b0;
    if (hold > 0) check({t, "_rsp_hold_stable"}, unstable, 0);

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_halted  = m_stall;
    check({t, "_rsp_valid_cleared"}, rsp_valid, 0);
    check({t, "_stall_after_rsp"}, pc_stall, m_stall);
    check({t, "_cmd_ready_after_rsp"}, cmd_ready, 1);
    check({t, "_rf_addr_idle"}, cm_regfile_addr, 0);
    check({t, "_we_pulses"}, we_pulses - we0, exp_we ? 1 : 0);
    if (exp_we) begin
      check({t, "_we_addr"}, we_addr, addr);
      check({t, "_we_data"}, we_data, data);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [31:0] ret0;
    logic [31:0] ret1;
    logic [2:0]  op;

    RST         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b0;
    cpu_idle    = 1'b1;
    cpu_retire  = 1'b0;
    rand_retire = 1'b0;
    m_stall     = 1'b1;
    m_halted    = 1'b1;
    clear_model_rf();
    repeat (3) tick();
    RST = 1'b0;

    check("reset_pc_stall", pc_stall, 1);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_we", cm_regfile_we, 0);
    check("reset_rf_addr", cm_regfile_addr, 0);

    do_cmd(DBG_OP_STATUS, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    check("status_reset_word", rd, 32'h3);
    check("status_latency", lat, 1);

    do_cmd(DBG_OP_REG_WR, 5'd5, 32'hDEADBEEF, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_REG_RD, 5'd5, 32'd0, 0, 0, 1'b0, lat, rd);
    check("regrd_x5", rd, 32'hDEADBEEF);
    check("regrd_latency", lat, 2);

    do_cmd(DBG_OP_RESUME, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_REG_RD, 5'd5, 32'd0, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_REG_WR, 5'd6, 32'h12345678, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_STEP, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    check("running_stall_low", pc_stall, 0);

    cpu_idle = 1'b0;
    do_cmd(DBG_OP_HALT, 5'd0, 32'd0, 0, 3, 1'b0, lat, rd);
    check("halt_idle_latency", lat, 4);

    do_cmd(DBG_OP_RESUME, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    cpu_idle = 1'b0;
    do_cmd(DBG_OP_HALT, 5'd0, 32'd0, 0, 0, 1'b1, lat, rd);
    check("halt_timeout_latency", lat, TMO + 1);
    cpu_idle = 1'b1;
    do_cmd(DBG_OP_STATUS, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);

    do_cmd(DBG_OP_RD_RETIRED, 5'd0, 32'd0, 0, 0, 1'b0, lat, ret0);
    do_cmd(DBG_OP_STEP, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_RD_RETIRED, 5'd0, 32'd0, 0, 0, 1'b0, lat, ret1);
    check("step_retired_delta", ret1 - ret0, 1);

    do_cmd(DBG_OP_STATUS, 5'd0, 32'd0, 10, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_RD_CYCLES, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);

    rand_retire = 1'b1;
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      do_cmd(op, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3), 0, 1'b0, lat, rd);
    end
    rand_retire = 1'b0;

    if (m_halted) do_cmd(DBG_OP_RESUME, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    cpu_idle = 1'b0;
    check("midop_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = DBG_OP_HALT;
    tick();
    cmd_valid = 1'b0;
    m_stall   = 1'b1;
    repeat (5) tick();
    check("midop_waiting", rsp_valid, 0);
    RST = 1'b1;
    tick();
    tick();
    RST      = 1'b0;
    cpu_idle = 1'b1;
    m_stall  = 1'b1;
    m_halted = 1'b1;
    clear_model_rf();
    check("midop_reset_stall", pc_stall, 1);
    check("midop_reset_ready", cmd_ready, 1);
    check("midop_reset_rsp_valid", rsp_valid, 0);
    check("midop_reset_rsp_err", rsp_err, 0);
    do_cmd(DBG_OP_STATUS, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_RD_CYCLES, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_RD_RETIRED, 5'd0, 32'd0, 0, 0, 1'b0, lat, rd);
    do_cmd(DBG_OP_REG_RD, 5'd5, 32'd0, 0, 0, 1'b0, lat, rd);

    check("we_while_unstalled", inv_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
